regfile_wport_arbiter: RTL and testbench
========================================

// Module: regfile_wport_arbiter
// PURPOSE
//  Shares the single register-file write port (regwrite/write_reg/write_data)
//  between two write requesters: A = pipeline write-back, B = multi-cycle unit
//  (mul/div, load return). Round-robin arbitration with valid/ready handshakes.
//  Drives the write port from registers, filters writes to x0 and counts commits.
// PARAMETERS
//  AW         5   register address width (32 architectural registers)
//  DW         32  data width
//  CW         16  width of wr_count commit counter
//  PRIO_RESET 0   requester holding priority after reset (0 = A, 1 = B)
// PORTS
//  clk         in   1   clock, all state updates on posedge
//  reset       in   1   asynchronous, active-high reset
//  a_valid     in   1   requester A has a write pending
//  a_ready     out  1   A's write accepted this cycle
//  a_reg       in   AW  A destination register
//  a_data      in   DW  A write data
//  b_valid     in   1   requester B has a write pending
//  b_ready     out  1   B's write accepted this cycle
//  b_reg       in   AW  B destination register
//  b_data      in   DW  B write data
//  regwrite    out  1   register-file write enable (registered)
//  write_reg   out  AW  register-file write address (registered)
//  write_data  out  DW  register-file write data (registered)
//  wr_count    out  CW  number of committed writes (regwrite pulses), wraps
// BEHAVIOUR
//  - State: priority pointer ptr in {PRI_A, PRI_B}; output regs; wr_count.
//  - Grant (combinational): a_ready = a_valid & (~b_valid | ptr==PRI_A);
//    b_ready = b_valid & (~a_valid | ptr==PRI_B). Never both high.
//  - Transfer = valid & ready. Requesters hold valid/reg/data stable until
//    ready; the arbiter does not check this.
//  - Pointer: after a transfer from A, ptr <= PRI_B; from B, ptr <= PRI_A;
//    no transfer -> ptr unchanged. A lone requester is granted every cycle.
//  - Latency 1: transfer in cycle N -> write_reg/write_data = transferred
//    values and regwrite = (reg != 0) in cycle N+1. No transfer -> regwrite=0,
//    write_reg/write_data hold last values.
//  - x0 writes: handshake completes (ready=1), regwrite stays 0, not counted.
//  - Throughput: one write per cycle; no internal buffering.
//  - Same register from A and B in one cycle: two separate writes in
//    ptr order; the later-granted data is final.
//  - wr_count += 1 on every cycle with regwrite=1; wraps 2^CW-1 -> 0.
//  - Reset (async, any time): regwrite=0, write_reg=0, write_data=0,
//    wr_count=0, ptr=PRIO_RESET; a_ready=b_ready=0 while reset high.
//    A transfer accepted in the cycle reset asserts is discarded (no write).
//  - First posedge after reset deassert behaves as a normal cycle.
// TESTING
//  1 Reset, PRIO_RESET=0; a_valid=1 a_reg=5 a_data=0x11 alone -> a_ready=1,
//    next cycle regwrite=1 write_reg=5 write_data=0x11, wr_count=1.
//  2 A(r3,0xA) and B(r4,0xB) valid 4 cycles, data held per handshake ->
//    grants A,B,A,B; regwrite every cycle from cycle 2; wr_count=4.
//  3 Both write r7 same cycle (A=0x1,B=0x2), ptr=PRI_B -> B first then A;
//    final write_data=0x1 at r7, two regwrite pulses.
//  4 a_reg=0 a_data=0xFF valid -> a_ready=1, regwrite stays 0, wr_count
//    unchanged; ptr still moves to PRI_B.
//  5 Assert reset mid-stream with B granted -> outputs 0 asynchronously,
//    no regwrite next cycle, after release ptr=PRIO_RESET, grants resume.
//  6 Force wr_count to 2^CW-1 (CW=4: 15 commits) + one commit -> wr_count=0.

Source files
------------

// File: rtl/regfile_wport_arbiter_if.sv
// regfile_wport_arbiter_if: two write-requester handshakes plus the shared register-file write port
interface regfile_wport_arbiter_if #(
   parameter int AW = 5,
   parameter int DW = 32,
   parameter int CW = 16
);
   logic          a_valid;
   logic          a_ready;
   logic [AW-1:0] a_reg;
   logic [DW-1:0] a_data;
   logic          b_valid;
   logic          b_ready;
   logic [AW-1:0] b_reg;
   logic [DW-1:0] b_data;
   logic          regwrite;
   logic [AW-1:0] write_reg;
   logic [DW-1:0] write_data;
   logic [CW-1:0] wr_count;
   modport master (
      output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
      input  a_ready, b_ready, regwrite, write_reg, write_data, wr_count
   );
   modport slave (
      input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
      output a_ready, b_ready, regwrite, write_reg, write_data, wr_count
   );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: round-robin sharing of one register-file write port between two requesters
module regfile_wport_arbiter #(
   parameter int AW         = 5,
   parameter int DW         = 32,
   parameter int CW         = 16,
   parameter int PRIO_RESET = 0
) (
   input logic clk,
   input logic reset,
   regfile_wport_arbiter_if.slave bus
);
   typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} ptr_t;
   ptr_t          ptr, ptr_nxt;
   logic          a_go, b_go, commit;
   logic [AW-1:0] sel_reg, write_reg;
   logic [DW-1:0] sel_data, write_data;
   logic [CW-1:0] wr_count;
   logic          regwrite;
   // Grants are masked during reset so no handshake completes while state is cleared
   always_comb begin
      a_go     = ~reset & bus.a_valid & (~bus.b_valid | ptr == PRI_A);
      b_go     = ~reset & bus.b_valid & (~bus.a_valid | ptr == PRI_B);
      ptr_nxt  = a_go ? PRI_B : b_go ? PRI_A : ptr;
      sel_reg  = a_go ? bus.a_reg : bus.b_reg;
      sel_data = a_go ? bus.a_data : bus.b_data;
      commit   = (a_go | b_go) & (sel_reg != '0);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) ptr <= (PRIO_RESET != 0) ? PRI_B : PRI_A;
      else ptr <= ptr_nxt;
   // x0 writes complete the handshake and update the address/data regs but never assert regwrite
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         regwrite   <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
         wr_count   <= '0;
      end else begin
         regwrite <= commit;
         if (a_go | b_go) begin
            write_reg  <= sel_reg;
            write_data <= sel_data;
         end
         if (commit) wr_count <= wr_count + CW'(1);
      end
   assign bus.a_ready    = a_go;
   assign bus.b_ready    = b_go;
   assign bus.regwrite   = regwrite;
   assign bus.write_reg  = write_reg;
   assign bus.write_data = write_data;
   assign bus.wr_count   = wr_count;
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: directed checks of grants, write-port latency, x0 filtering, reset and counter wrap
module tb_regfile_wport_arbiter;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int CW = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_checks = 0;
   int n_fail = 0;
   regfile_wport_arbiter_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();
   regfile_wport_arbiter #(.AW(AW), .DW(DW), .CW(CW), .PRIO_RESET(0)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic set_a(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
      bus.a_valid = v;
      bus.a_reg   = r;
      bus.a_data  = d;
   endtask
   task automatic set_b(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
      bus.b_valid = v;
      bus.b_reg   = r;
      bus.b_data  = d;
   endtask
   task automatic check_wp(input string tag, input logic we, input logic [AW-1:0] r, input logic [DW-1:0] d, input logic [CW-1:0] c);
      check({tag, "_regwrite"}, 64'(bus.regwrite), 64'(we));
      check({tag, "_write_reg"}, 64'(bus.write_reg), 64'(r));
      check({tag, "_write_data"}, 64'(bus.write_data), 64'(d));
      check({tag, "_wr_count"}, 64'(bus.wr_count), 64'(c));
   endtask
   task automatic check_rdy(input string tag, input logic a, input logic b);
      check({tag, "_a_ready"}, 64'(bus.a_ready), 64'(a));
      check({tag, "_b_ready"}, 64'(bus.b_ready), 64'(b));
   endtask
   initial begin
      set_a(1'b1, 5'd1, 32'h1);
      set_b(1'b1, 5'd2, 32'h2);
      #2;
      check_rdy("rst_hold", 1'b0, 1'b0);
      check_wp("rst_hold", 1'b0, 5'd0, 32'h0, 4'd0);
      tick();
      tick();
      reset = 1'b0;
      // lone A write to r5
      set_a(1'b1, 5'd5, 32'h11);
      set_b(1'b0, 5'd0, 32'h0);
      #1;
      check_rdy("t1", 1'b1, 1'b0);
      tick();
      set_a(1'b0, 5'd0, 32'h0);
      check_wp("t1", 1'b1, 5'd5, 32'h11, 4'd1);
      tick();
      check_wp("idle_hold", 1'b0, 5'd5, 32'h11, 4'd1);
      // lone B returns priority to A
      set_b(1'b1, 5'd9, 32'h99);
      #1;
      check_rdy("lone_b", 1'b0, 1'b1);
      tick();
      check_wp("lone_b", 1'b1, 5'd9, 32'h99, 4'd2);
      // both requesting: A,B,A,B
      set_a(1'b1, 5'd3, 32'hA);
      set_b(1'b1, 5'd4, 32'hB);
      for (int i = 0; i < 4; i++) begin
         #1;
         check_rdy($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1);
         tick();
         check_wp($sformatf("rr%0d", i), 1'b1, (i % 2) == 0 ? 5'd3 : 5'd4,
                  (i % 2) == 0 ? 32'hA : 32'hB, CW'(3 + i));
      end
      // x0 write from A: handshake, no commit, priority moves to B
      set_b(1'b0, 5'd0, 32'h0);
      set_a(1'b1, 5'd0, 32'hFF);
      #1;
      check_rdy("x0", 1'b1, 1'b0);
      tick();
      check_wp("x0", 1'b0, 5'd0, 32'hFF, 4'd6);
      // same register from both with B holding priority
      set_a(1'b1, 5'd7, 32'h1);
      set_b(1'b1, 5'd7, 32'h2);
      #1;
      check_rdy("same_b", 1'b0, 1'b1);
      tick();
      check_wp("same_b", 1'b1, 5'd7, 32'h2, 4'd7);
      set_b(1'b0, 5'd0, 32'h0);
      #1;
      check_rdy("same_a", 1'b1, 1'b0);
      tick();
      check_wp("same_a", 1'b1, 5'd7, 32'h1, 4'd8);
      // reset asserted mid-cycle while B is granted
      set_a(1'b1, 5'd1, 32'h5);
      set_b(1'b1, 5'd2, 32'h6);
      #1;
      check_rdy("pre_rst", 1'b0, 1'b1);
      reset = 1'b1;
      #1;
      check_rdy("async_rst", 1'b0, 1'b0);
      check_wp("async_rst", 1'b0, 5'd0, 32'h0, 4'd0);
      tick();
      check_wp("rst_edge", 1'b0, 5'd0, 32'h0, 4'd0);
      reset = 1'b0;
      #1;
      check_rdy("post_rst", 1'b1, 1'b0);
      tick();
      check_wp("post_rst_a", 1'b1, 5'd1, 32'h5, 4'd1);
      check_rdy("post_rst_b", 1'b0, 1'b1);
      tick();
      check_wp("post_rst_b", 1'b1, 5'd2, 32'h6, 4'd2);
      set_b(1'b0, 5'd0, 32'h0);
      // counter wrap: lone A commits every cycle
      for (int i = 0; i < 14; i++) begin
         set_a(1'b1, 5'(i + 10), 32'(i + 32'h100));
         #1;
         check($sformatf("wrap_rdy%0d", i), 64'(bus.a_ready), 64'd1);
         tick();
         if (i == 12) check_wp("wrap_max", 1'b1, 5'(i + 10), 32'(i + 32'h100), 4'd15);
      end
      check_wp("wrap_zero", 1'b1, 5'd23, 32'h10D, 4'd0);
      set_a(1'b0, 5'd0, 32'h0);
      tick();
      check_wp("wrap_idle", 1'b0, 5'd23, 32'h10D, 4'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
